// File: rtl/decode_stage_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, ALU and memory-size
// encodings, the decoded control bundle and a register-range helper.
package decode_stage_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes resolved in ID
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    // EX ALU operation selector
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_OPCODE = 2'b11;

    // MEM access size
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        DEST_RD  = 2'd0,
        DEST_RT  = 2'd1,
        DEST_R31 = 2'd2
    } dest_sel_e;

    typedef enum logic [1:0] {
        FLOW_NONE   = 2'd0,
        FLOW_BRANCH = 2'd1,
        FLOW_JUMP   = 2'd2,
        FLOW_JREG   = 2'd3
    } flow_e;

    // Control carried into EX/MEM/WB
    typedef struct packed {
        logic       wb_mem_to_reg;
        logic       wb_write_reg;
        logic       mem_read;
        logic       mem_write;
        logic       mem_signed;
        logic [1:0] mem_size;
        logic [1:0] alu_op;
        logic       alu_src;
    } ctrl_t;

    // Full decode result consumed inside ID
    typedef struct packed {
        ctrl_t     ctrl;
        logic      use_rs;
        logic      use_rt;
        logic      zero_ext;
        logic      link;
        logic      bne;
        flow_e     flow;
        dest_sel_e dest_sel;
    } decode_t;

    // True when a register index maps onto an implemented register
    function automatic logic reg_implemented(input logic [4:0] addr, input int unsigned n);
        return (32'(addr) < n);
    endfunction

endpackage

// File: rtl/decode_stage_control.sv
// Purely combinational opcode/funct decoder producing the control bundle,
// source-use flags, immediate-extend mode and control-flow class.
module decode_control
    import decode_stage_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output decode_t    dec_c_o
);

    decode_t dec;

    // Opcode/funct to control; unknown encodings fall through as a NOP
    always_comb begin
        dec          = '0;
        dec.flow     = FLOW_NONE;
        dec.dest_sel = DEST_RT;
        case (opcode_i)
            OP_RTYPE: begin
                dec.use_rs = 1'b1;
                if (funct_i == FN_JR) begin
                    dec.flow = FLOW_JREG;
                end else if (funct_i == FN_JALR) begin
                    dec.flow              = FLOW_JREG;
                    dec.link              = 1'b1;
                    dec.ctrl.wb_write_reg = 1'b1;
                    dec.ctrl.alu_src      = 1'b1;
                    dec.ctrl.alu_op       = ALU_ADD;
                    dec.dest_sel          = DEST_RD;
                end else begin
                    dec.use_rt            = 1'b1;
                    dec.ctrl.wb_write_reg = 1'b1;
                    dec.ctrl.alu_op       = ALU_FUNCT;
                    dec.dest_sel          = DEST_RD;
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.use_rs             = 1'b1;
                dec.ctrl.mem_read      = 1'b1;
                dec.ctrl.wb_mem_to_reg = 1'b1;
                dec.ctrl.wb_write_reg  = 1'b1;
                dec.ctrl.alu_src       = 1'b1;
                dec.ctrl.alu_op        = ALU_ADD;
                dec.ctrl.mem_signed    = (opcode_i == OP_LB) || (opcode_i == OP_LH) ||
                                         (opcode_i == OP_LW);
                if (opcode_i == OP_LW) begin
                    dec.ctrl.mem_size = MEM_WORD;
                end else if ((opcode_i == OP_LH) || (opcode_i == OP_LHU)) begin
                    dec.ctrl.mem_size = MEM_HALF;
                end else begin
                    dec.ctrl.mem_size = MEM_BYTE;
                end
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.use_rs         = 1'b1;
                dec.use_rt         = 1'b1;
                dec.ctrl.mem_write = 1'b1;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.alu_op    = ALU_ADD;
                if (opcode_i == OP_SW) begin
                    dec.ctrl.mem_size = MEM_WORD;
                end else if (opcode_i == OP_SH) begin
                    dec.ctrl.mem_size = MEM_HALF;
                end else begin
                    dec.ctrl.mem_size = MEM_BYTE;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.use_rs            = (opcode_i != OP_LUI);
                dec.ctrl.wb_write_reg = 1'b1;
                dec.ctrl.alu_src      = 1'b1;
                dec.ctrl.alu_op       = ALU_OPCODE;
                dec.zero_ext          = (opcode_i == OP_ANDI) || (opcode_i == OP_ORI) ||
                                        (opcode_i == OP_XORI);
            end
            OP_BEQ, OP_BNE: begin
                dec.use_rs      = 1'b1;
                dec.use_rt      = 1'b1;
                dec.ctrl.alu_op = ALU_SUB;
                dec.flow        = FLOW_BRANCH;
                dec.bne         = (opcode_i == OP_BNE);
            end
            OP_J: begin
                dec.flow = FLOW_JUMP;
            end
            OP_JAL: begin
                dec.flow              = FLOW_JUMP;
                dec.link              = 1'b1;
                dec.ctrl.wb_write_reg = 1'b1;
                dec.ctrl.alu_src      = 1'b1;
                dec.ctrl.alu_op       = ALU_ADD;
                dec.dest_sel          = DEST_R31;
            end
            default: begin
            end
        endcase
    end

    assign dec_c_o = dec;

endmodule

// File: rtl/decode_stage_regbank.sv
// Register bank: two combinational read ports, one write port, r0 hard-wired
// to zero, unimplemented indices read zero and drop writes, cleared on reset.
module register_bank
    import decode_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [4:0]            raddr_a_i,
    input  logic [4:0]            raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_a_c_o,
    output logic [DATA_WIDTH-1:0] rdata_b_c_o
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // Synchronous clear, then guarded writes (never r0, never past the bank)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO) && reg_implemented(waddr_i, NUM_REGS)) begin
            regs_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    // Read-old ports; out-of-range indices return zero
    always_comb begin
        rdata_a_c_o = '0;
        rdata_b_c_o = '0;
        if (reg_implemented(raddr_a_i, NUM_REGS)) rdata_a_c_o = regs_q[raddr_a_i[AW-1:0]];
        if (reg_implemented(raddr_b_i, NUM_REGS)) rdata_b_c_o = regs_q[raddr_b_i[AW-1:0]];
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: register bank, decode, branch/jump resolution, hazard
// stall/flush and the ID/EX pipeline register.
// Build option WB_BYPASS_EN: forward a same-cycle WB write into the operands;
// when undefined the bank is read-old and a matching WB write stalls ID.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [31:0]           i_instruction,
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic                  i_valid,
    input  logic                  i_wb_write_enable,
    input  logic [4:0]            i_wb_write_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_write_data,
    input  logic                  i_ex_write_reg,
    input  logic                  i_ex_mem_read,
    input  logic [4:0]            i_ex_dest,
    input  logic                  i_mem_mem_read,
    input  logic [4:0]            i_mem_dest,
    input  logic                  i_halt,
    output logic [DATA_WIDTH-1:0] o_RA,
    output logic [DATA_WIDTH-1:0] o_RB,
    output logic [4:0]            o_rs,
    output logic [4:0]            o_rt,
    output logic [4:0]            o_rd,
    output logic [4:0]            o_shamt,
    output logic [5:0]            o_funct,
    output logic [5:0]            o_opcode,
    output logic [DATA_WIDTH-1:0] o_inmediato,
    output logic                  o_valid,
    output logic                  o_WB_mem_to_reg,
    output logic                  o_WB_write_reg,
    output logic                  o_MEM_mem_read,
    output logic                  o_MEM_mem_write,
    output logic                  o_MEM_signed,
    output logic [1:0]            o_MEM_size,
    output logic [1:0]            o_EX_ALU_op,
    output logic                  o_EX_ALU_src,
    output logic                  o_stall,
    output logic                  o_jump,
    output logic [PC_WIDTH-1:0]   o_jump_address,
    output logic                  o_flush_if
);

    localparam logic [PC_WIDTH-1:0] PC_LOW28 = PC_WIDTH'(32'h0FFF_FFFF);

    logic [4:0]  rs_c, rt_c, rd_c, shamt_c;
    logic [5:0]  opcode_c, funct_c;
    logic [15:0] imm16_c;
    decode_t     dec_c;

    assign opcode_c = i_instruction[31:26];
    assign rs_c     = i_instruction[25:21];
    assign rt_c     = i_instruction[20:16];
    assign rd_c     = i_instruction[15:11];
    assign shamt_c  = i_instruction[10:6];
    assign funct_c  = i_instruction[5:0];
    assign imm16_c  = i_instruction[15:0];

    decode_control u_decode_control (
        .opcode_i (opcode_c),
        .funct_i  (funct_c),
        .dec_c_o  (dec_c)
    );

    logic [DATA_WIDTH-1:0] bank_ra_c, bank_rb_c;

    register_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_register_bank (
        .clk_i       (i_clk),
        .rst_ni      (i_reset),
        .we_i        (i_wb_write_enable),
        .waddr_i     (i_wb_write_addr),
        .wdata_i     (i_wb_write_data),
        .raddr_a_i   (rs_c),
        .raddr_b_i   (rt_c),
        .rdata_a_c_o (bank_ra_c),
        .rdata_b_c_o (bank_rb_c)
    );

    // A WB write that will actually land in the bank this edge
    logic wb_live_c;
    assign wb_live_c = i_wb_write_enable && (i_wb_write_addr != REG_ZERO) &&
                       reg_implemented(i_wb_write_addr, NUM_REGS);

    // A non-zero destination that feeds one of this instruction's sources
    function automatic logic src_match(input logic [4:0] dest, input decode_t dec,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return (dest != REG_ZERO) &&
               ((dec.use_rs && (dest == rs)) || (dec.use_rt && (dest == rt)));
    endfunction

    logic [DATA_WIDTH-1:0] ra_c, rb_c;
    logic                  wb_hz_c;

`ifdef WB_BYPASS_EN
    // Write-first forwarding of the same-cycle WB result
    always_comb begin
        ra_c    = bank_ra_c;
        rb_c    = bank_rb_c;
        wb_hz_c = 1'b0;
        if (wb_live_c && (i_wb_write_addr == rs_c)) ra_c = i_wb_write_data;
        if (wb_live_c && (i_wb_write_addr == rt_c)) rb_c = i_wb_write_data;
    end
`else
    // Read-old bank; a matching in-flight WB write holds ID one cycle
    always_comb begin
        ra_c    = bank_ra_c;
        rb_c    = bank_rb_c;
        wb_hz_c = wb_live_c && src_match(i_wb_write_addr, dec_c, rs_c, rt_c);
    end
`endif

    logic load_use_c, branch_hz_c, stall_raw_c, taken_c;

    // Hazard detection: load-use, ID-resolved control-flow operands, WB
    always_comb begin
        load_use_c  = i_ex_mem_read && (i_ex_dest != REG_ZERO) &&
                      ((i_ex_dest == rs_c) || (dec_c.use_rt && (i_ex_dest == rt_c)));
        branch_hz_c = ((dec_c.flow == FLOW_BRANCH) || (dec_c.flow == FLOW_JREG)) &&
                      ((i_ex_write_reg && src_match(i_ex_dest, dec_c, rs_c, rt_c)) ||
                       (i_mem_mem_read && src_match(i_mem_dest, dec_c, rs_c, rt_c)));
        stall_raw_c = i_valid && (load_use_c || branch_hz_c || wb_hz_c);
    end

    // Branch/jump resolution and target selection
    always_comb begin
        taken_c        = 1'b0;
        o_jump_address = '0;
        case (dec_c.flow)
            FLOW_BRANCH: begin
                taken_c        = (ra_c == rb_c) ^ dec_c.bne;
                o_jump_address = i_pc + {{(PC_WIDTH-18){imm16_c[15]}}, imm16_c, 2'b00};
            end
            FLOW_JUMP: begin
                taken_c        = 1'b1;
                o_jump_address = (i_pc & ~PC_LOW28) | PC_WIDTH'({i_instruction[25:0], 2'b00});
            end
            FLOW_JREG: begin
                taken_c        = 1'b1;
                o_jump_address = PC_WIDTH'(ra_c);
            end
            default: begin
            end
        endcase
    end

    assign o_stall    = i_reset && stall_raw_c;
    assign o_jump     = i_reset && taken_c && i_valid && !stall_raw_c && !i_halt;
    assign o_flush_if = o_jump;

    logic [DATA_WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, imm_q, imm_d;
    logic [4:0]            rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
    logic [5:0]            funct_q, funct_d, opcode_q, opcode_d;
    logic                  valid_q, valid_d;
    ctrl_t                 ctrl_q, ctrl_d;

    // ID/EX next state: halt holds, stall or empty slot bubbles, else load
    always_comb begin
        ra_d     = ra_q;
        rb_d     = rb_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        shamt_d  = shamt_q;
        funct_d  = funct_q;
        opcode_d = opcode_q;
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        if (i_halt) begin
            // hold
        end else if (stall_raw_c || !i_valid) begin
            ra_d     = '0;
            rb_d     = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            shamt_d  = '0;
            funct_d  = '0;
            opcode_d = '0;
            valid_d  = 1'b0;
            ctrl_d   = '0;
        end else begin
            ra_d     = dec_c.link ? DATA_WIDTH'(i_pc) : ra_c;
            rb_d     = rb_c;
            if (dec_c.link) begin
                imm_d = '0;
            end else if (dec_c.zero_ext) begin
                imm_d = {{(DATA_WIDTH-16){1'b0}}, imm16_c};
            end else begin
                imm_d = {{(DATA_WIDTH-16){imm16_c[15]}}, imm16_c};
            end
            rs_d     = rs_c;
            rt_d     = rt_c;
            case (dec_c.dest_sel)
                DEST_RD:  rd_d = rd_c;
                DEST_R31: rd_d = REG_RA;
                default:  rd_d = rt_c;
            endcase
            shamt_d  = shamt_c;
            funct_d  = funct_c;
            opcode_d = opcode_c;
            valid_d  = 1'b1;
            ctrl_d   = dec_c.ctrl;
        end
    end

    // ID/EX register with synchronous clear
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ra_q     <= '0;
            rb_q     <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            shamt_q  <= '0;
            funct_q  <= '0;
            opcode_q <= '0;
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            shamt_q  <= shamt_d;
            funct_q  <= funct_d;
            opcode_q <= opcode_d;
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign o_RA            = ra_q;
    assign o_RB            = rb_q;
    assign o_inmediato     = imm_q;
    assign o_rs            = rs_q;
    assign o_rt            = rt_q;
    assign o_rd            = rd_q;
    assign o_shamt         = shamt_q;
    assign o_funct         = funct_q;
    assign o_opcode        = opcode_q;
    assign o_valid         = valid_q;
    assign o_WB_mem_to_reg = ctrl_q.wb_mem_to_reg;
    assign o_WB_write_reg  = ctrl_q.wb_write_reg;
    assign o_MEM_mem_read  = ctrl_q.mem_read;
    assign o_MEM_mem_write = ctrl_q.mem_write;
    assign o_MEM_signed    = ctrl_q.mem_signed;
    assign o_MEM_size      = ctrl_q.mem_size;
    assign o_EX_ALU_op     = ctrl_q.alu_op;
    assign o_EX_ALU_src    = ctrl_q.alu_src;

endmodule
